// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver: frame FSM states,
// prefix bytes and the decoded-key record queued in the FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_key_t;

  // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the asynchronous PS/2 clock and data into the clk domain, debounces the
// clock over FILTER_LEN samples and emits a one-cycle pulse on each filtered falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps_clk,
  input  logic ps_data,
  output logic fall,
  output logic data_s
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;

  // NOTE: non-blocking assignments make every stage sample its pre-edge value;
  // blocking ones would collapse the two-flop synchroniser into a single flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps_clk};
      data_sync <= {data_sync[0], ps_data};
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive differing samples: accept the new level.
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, checks parity/stop, folds E0/F0
// prefixes into flags and queues keys in a FIFO. PS2_ERR_COUNT_EN adds err_count.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             ps_clk,
  input  logic                             ps_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [7:0]                       out_code,
  output logic                             out_ext,
  output logic                             out_brk,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             ovf,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
`ifdef PS2_ERR_COUNT_EN
  ,
  output logic [7:0]                       err_count
`endif
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic          fall;
  logic          data_s;
  ps2_state_e    state, state_nx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_q, brk_q;
  logic          start_err, stop_err, par_fail, byte_good, timeout;
  logic          push_req;
  ps2_key_t      push_key;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .ps_clk  (ps_clk),
    .ps_data (ps_data),
    .fall    (fall),
    .data_s  (data_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    start_err = 1'b0;
    stop_err  = 1'b0;
    par_fail  = 1'b0;
    byte_good = 1'b0;
    timeout   = 1'b0;
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC)) begin
      timeout  = 1'b1;
      state_nx = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!data_s) state_nx = DATA;
          else         start_err = 1'b1;
        end
        DATA:   if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (!data_s)                            stop_err  = 1'b1;
          else if (!odd_parity_ok(shift, par_bit)) par_fail  = 1'b1;
          else                                    byte_good = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      push_req   <= 1'b0;
      push_key   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (fall || state_nx == IDLE) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;

      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shift   <= {data_s, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par_bit <= data_s;

      parity_err <= par_fail;
      frame_err  <= start_err | stop_err | timeout;
      push_req   <= 1'b0;

      if (byte_good) begin
        if (shift == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (shift == PS2_BRK) begin
          brk_q <= 1'b1;
        end else begin
          push_req <= 1'b1;
          push_key <= '{ext: ext_q, brk: brk_q, code: shift};
          ext_q    <= 1'b0;
          brk_q    <= 1'b0;
        end
      end else if (start_err | stop_err | par_fail | timeout) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  ps2_key_t          mem [FIFO_DEPTH];
  ps2_key_t          head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, pop, push;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = push_req & (~full | pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_key;
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_code   = out_valid ? head.code : 8'h00;
  assign out_ext    = out_valid & head.ext;
  assign out_brk    = out_valid & head.brk;
  assign fifo_count = count;

`ifdef PS2_ERR_COUNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                        err_count <= 8'h00;
    else if ((parity_err | frame_err) && err_count != 8'hFF) err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and checks decoded
// keys, error pulses, FIFO overflow, timeout and mid-frame reset against hand-computed values.
module tb_ps2_scancode_rx;

  localparam int CLK_HZ      = 50_000_000;
  localparam int TIMEOUT_US  = 20;
  localparam int TIMEOUT_CYC = 1000;  // 50 cycles/us * 20 us
  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int HALF        = 25;    // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps_clk = 1'b1;
  logic       ps_data = 1'b1;
  logic       out_ready = 1'b1;
  logic       out_valid, out_ext, out_brk, parity_err, frame_err, ovf;
  logic [7:0] out_code;
  logic [3:0] fifo_count;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] got [0:63];
  int got_n = 0;
  int par_n = 0;
  int frm_n = 0;

  ps2_scancode_rx #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps_clk     (ps_clk),
    .ps_data    (ps_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_ext    (out_ext),
    .out_brk    (out_brk),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .ovf        (ovf),
    .fifo_count (fifo_count)
`ifdef PS2_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #10 clk = ~clk;

  // Records every accepted key and every cycle an error pulse is high.
  always @(negedge clk) begin
    if (out_valid && out_ready && got_n < 64) begin
      got[got_n] <= {out_ext, out_brk, out_code};
      got_n      <= got_n + 1;
    end
    if (parity_err) par_n <= par_n + 1;
    if (frame_err)  frm_n <= frm_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code, input logic flip);
    return {1'b1, (~^code) ^ flip, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps_data = bits[i];
      wait_cyc(HALF);
      ps_clk = 1'b0;
      wait_cyc(HALF);
      ps_clk = 1'b1;
    end
  endtask

  task automatic send_key(input logic [7:0] code);
    send_bits(frame(code, 1'b0), 11);
    ps_data = 1'b1;
    wait_cyc(60);
  endtask

  int r, p0, f0, elapsed;

  initial begin
    wait_cyc(5);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_code",  out_code, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_errs",  {parity_err, frame_err}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_cyc(5);

    // Plain make code
    r = got_n; p0 = par_n; f0 = frm_n;
    send_key(8'h1C);
    @(negedge clk);
    check("t1_nkeys", got_n - r, 1);
    check("t1_key",   got[r], {2'b00, 8'h1C});
    check("t1_perr",  par_n - p0, 0);
    check("t1_ferr",  frm_n - f0, 0);

    // Break and extended-break prefixes
    r = got_n;
    send_key(8'hF0);
    send_key(8'h1C);
    @(negedge clk);
    check("t2_brk_nkeys", got_n - r, 1);
    check("t2_brk_key",   got[r], {2'b01, 8'h1C});
    r = got_n;
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    @(negedge clk);
    check("t2_extbrk_nkeys", got_n - r, 1);
    check("t2_extbrk_key",   got[r], {2'b11, 8'h75});

    // Parity failure, then recovery
    r = got_n; p0 = par_n; f0 = frm_n;
    send_bits(frame(8'h1C, 1'b1), 11);
    wait_cyc(60);
    @(negedge clk);
    check("t3_perr_cycles", par_n - p0, 1);
    check("t3_no_key",      got_n - r, 0);
    check("t3_no_ferr",     frm_n - f0, 0);
    send_key(8'h1D);
    @(negedge clk);
    check("t3_next_key", got[r], {2'b00, 8'h1D});

    // Overflow with the consumer stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_key(8'(8'h10 + i));
    @(negedge clk);
    check("t4_count", fifo_count, 8);
    check("t4_ovf",   ovf, 1);
    check("t4_head",  {out_valid, out_code}, {1'b1, 8'h10});
    r = got_n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_cyc(20);
    @(negedge clk);
    check("t4_drained", got_n - r, 8);
    for (int i = 0; i < 8; i++) check("t4_order", got[r + i], {2'b00, 8'(8'h10 + i)});
    check("t4_empty", fifo_count, 0);
    check("t4_ovf_sticky", ovf, 1);

    // Truncated frame times out
    r = got_n; f0 = frm_n;
    send_bits(frame(8'h55, 1'b0), 5);
    elapsed = 0;
    while (elapsed < TIMEOUT_CYC + 200 && frm_n == f0) begin
      @(negedge clk);
      elapsed++;
    end
    check("t5_timeout_pulse", frm_n - f0, 1);
    check("t5_timeout_window",
          (elapsed >= TIMEOUT_CYC - 2 * HALF) && (elapsed <= TIMEOUT_CYC + 20), 1);
    check("t5_no_key", got_n - r, 0);
    send_key(8'h2C);
    @(negedge clk);
    check("t5_next_key", got[r], {2'b00, 8'h2C});

    // Reset mid-frame with a pending E0 prefix
    send_key(8'hE0);
    send_bits(frame(8'h6B, 1'b0), 4);
    resetn = 1'b0;
    #1;
    check("t6_rst_outputs", {out_valid, ovf, parity_err, frame_err, out_ext, out_brk}, 0);
    check("t6_rst_count", fifo_count, 0);
    wait_cyc(5);
    ps_data = 1'b1;
    resetn  = 1'b1;
    wait_cyc(5);
    r = got_n;
    send_key(8'h23);
    @(negedge clk);
    check("t6_nkeys", got_n - r, 1);
    check("t6_key",   got[r], {2'b00, 8'h23});

`ifdef PS2_ERR_COUNT_EN
    for (int i = 0; i < 300; i++) send_bits(11'h7FF, 1);
    wait_cyc(20);
    @(negedge clk);
    check("t6_err_count_sat", err_count, 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
